// File: rtl/tx_scheduler_if.sv
// UART transmit scheduler bundle: register-side pushes,
// frontend launch/done handshake and shadowed frame config.
interface tx_scheduler_if #(
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          push_i;
  logic [7:0]    push_data_i;
  logic          flush_i;
  logic          enable_i;
  logic [15:0]   cr_clk_div_i;
  logic          cr_ds_i;
  logic [1:0]    cr_p_i;
  logic          cr_s_i;
  logic          done_i;
  logic          transmit_o;
  logic [7:0]    dr_o;
  logic [15:0]   clk_div_o;
  logic          ds_o;
  logic [1:0]    p_o;
  logic          s_o;
  logic          busy_o;
  logic          empty_o;
  logic          full_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;

  modport master (
    output push_i, push_data_i, flush_i, enable_i,
    output cr_clk_div_i, cr_ds_i, cr_p_i, cr_s_i, done_i,
    input  transmit_o, dr_o, clk_div_o, ds_o, p_o, s_o,
    input  busy_o, empty_o, full_o, level_o, overflow_o
  );

  modport slave (
    input  push_i, push_data_i, flush_i, enable_i,
    input  cr_clk_div_i, cr_ds_i, cr_p_i, cr_s_i, done_i,
    output transmit_o, dr_o, clk_div_o, ds_o, p_o, s_o,
    output busy_o, empty_o, full_o, level_o, overflow_o
  );
endinterface

// File: rtl/tx_scheduler.sv
// UART transmit scheduler: byte FIFO plus launch/wait FSM
// that shadows the frame config at every launch.
module tx_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  tx_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  logic [1:0]    state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          empty_q;
  logic          full_q;
  logic          ovf_q;
  logic          tx_q;
  logic          busy_q;
  logic [7:0]    dr_q;
  logic [15:0]   div_q;
  logic          ds_q;
  logic [1:0]    p_q;
  logic          s_q;
  logic          push_ok;
  logic          pop;

  // Push uses pre-pop fullness; launch needs idle, enable and data.
  always_comb begin
    push_ok = bus.push_i & ~full_q & ~bus.flush_i;
    pop     = (state_q == IDLE) & bus.enable_i
            & ~empty_q & ~bus.flush_i;
    level_d = level_q
            + {{(LW-1){1'b0}}, push_ok}
            - {{(LW-1){1'b0}}, pop};
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wp_q] <= bus.push_data_i;
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= bus.push_i & full_q & ~bus.flush_i;
      if (bus.flush_i) begin
        wp_q    <= '0;
        rp_q    <= '0;
        level_q <= '0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
      end else begin
        if (push_ok) wp_q <= wp_q + 1'b1;
        if (pop)     rp_q <= rp_q + 1'b1;
        level_q <= level_d;
        empty_q <= (level_d == '0);
        full_q  <= (level_d == LW'(DEPTH));
      end
    end
  end

  // Launch FSM with byte and config shadows.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      dr_q    <= '0;
      div_q   <= '0;
      ds_q    <= 1'b0;
      p_q     <= '0;
      s_q     <= 1'b0;
    end else begin
      tx_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= LAUNCH;
            tx_q    <= 1'b1;
            busy_q  <= 1'b1;
            dr_q    <= mem_q[rp_q];
            div_q   <= bus.cr_clk_div_i;
            ds_q    <= bus.cr_ds_i;
            p_q     <= bus.cr_p_i;
            s_q     <= bus.cr_s_i;
          end
        end
        LAUNCH: state_q <= WAIT;
        WAIT: begin
          if (bus.done_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.transmit_o = tx_q;
  assign bus.busy_o     = busy_q;
  assign bus.dr_o       = dr_q;
  assign bus.clk_div_o  = div_q;
  assign bus.ds_o       = ds_q;
  assign bus.p_o        = p_q;
  assign bus.s_o        = s_q;
  assign bus.empty_o    = empty_q;
  assign bus.full_o     = full_q;
  assign bus.level_o    = level_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: vector table plus
// hand sequences for spacing, flush and async reset.
module tb_tx_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tx_scheduler_if #(.DEPTH(4)) bus ();

  tx_scheduler #(.DEPTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        push;
    logic [7:0]  data;
    logic        flush;
    logic        en;
    logic        done;
    logic [15:0] div;
    logic        tx;
    logic        busy;
    logic [7:0]  dr;
    logic [2:0]  lvl;
    logic        emp;
    logic        full;
    logic        ovf;
    logic [15:0] odiv;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(
    logic p, logic [7:0] d, logic f, logic e, logic dn,
    logic [15:0] dv, logic tx, logic b, logic [7:0] dr,
    logic [2:0] l, logic em, logic fu, logic ov,
    logic [15:0] od);
    vec_t v;
    v.push = p; v.data = d; v.flush = f; v.en = e;
    v.done = dn; v.div = dv; v.tx = tx; v.busy = b;
    v.dr = dr; v.lvl = l; v.emp = em; v.full = fu;
    v.ovf = ov; v.odiv = od;
    return v;
  endfunction

  // {tx, busy, dr, lvl, empty, full, ovf, div, ds, p, s}
  function automatic logic [35:0] snap();
    return {bus.transmit_o, bus.busy_o, bus.dr_o,
            bus.level_o, bus.empty_o, bus.full_o,
            bus.overflow_o, bus.clk_div_o,
            bus.ds_o, bus.p_o, bus.s_o};
  endfunction

  function automatic logic [35:0] pk(
    logic tx, logic b, logic [7:0] dr, logic [2:0] l,
    logic em, logic fu, logic ov, logic [15:0] od,
    logic [3:0] sh);
    return {tx, b, dr, l, em, fu, ov, od, sh};
  endfunction

  task automatic check(string name, logic [35:0] exp);
    logic [35:0] act;
    act = snap();
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.push_i = 1'b0;
    bus.push_data_i = 8'h00;
    bus.flush_i = 1'b0;
    bus.done_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] SH = 4'b1101;
  localparam logic [35:0] RST = {1'b0, 1'b0, 8'h00, 3'd0,
    1'b1, 1'b0, 1'b0, 16'h0, 4'h0};

  initial begin
    logic [7:0] seq [3];
    logic [3:0] sh;
    int k;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;

    tbl[0]  = mk(1,8'hA5,0,1,1,868, 0,0,8'h00,0+1,0,0,0,0);
    tbl[1]  = mk(0,8'h00,0,1,0,868, 1,1,8'hA5,0,1,0,0,868);
    tbl[2]  = mk(0,8'h00,0,1,1,868, 0,1,8'hA5,0,1,0,0,868);
    tbl[3]  = mk(1,8'h11,0,1,0,868, 0,1,8'hA5,1,0,0,0,868);
    tbl[4]  = mk(1,8'h22,0,1,0,868, 0,1,8'hA5,2,0,0,0,868);
    tbl[5]  = mk(1,8'h33,0,1,0,434, 0,1,8'hA5,3,0,0,0,868);
    tbl[6]  = mk(0,8'h00,0,1,1,434, 0,0,8'hA5,3,0,0,0,868);
    tbl[7]  = mk(0,8'h00,0,1,0,434, 1,1,8'h11,2,0,0,0,434);
    tbl[8]  = mk(0,8'h00,0,1,1,434, 0,1,8'h11,2,0,0,0,434);
    tbl[9]  = mk(0,8'h00,0,1,1,434, 0,0,8'h11,2,0,0,0,434);
    tbl[10] = mk(1,8'h44,1,1,0,434, 0,0,8'h11,0,1,0,0,434);
    tbl[11] = mk(1,8'h55,0,0,0,434, 0,0,8'h11,1,0,0,0,434);
    tbl[12] = mk(1,8'h66,0,0,0,434, 0,0,8'h11,2,0,0,0,434);
    tbl[13] = mk(1,8'h77,0,0,0,434, 0,0,8'h11,3,0,0,0,434);
    tbl[14] = mk(1,8'h88,0,0,0,434, 0,0,8'h11,4,0,1,0,434);
    tbl[15] = mk(1,8'h99,0,0,0,434, 0,0,8'h11,4,0,1,1,434);
    tbl[16] = mk(0,8'h00,0,0,0,434, 0,0,8'h11,4,0,1,0,434);
    tbl[17] = mk(1,8'hAA,0,1,0,434, 1,1,8'h55,3,0,0,1,434);
    tbl[18] = mk(0,8'h00,0,1,0,434, 0,1,8'h55,3,0,0,0,434);
    tbl[19] = mk(0,8'h00,0,1,1,434, 0,0,8'h55,3,0,0,0,434);
    tbl[20] = mk(0,8'h00,0,1,0,434, 1,1,8'h66,2,0,0,0,434);

    idle_in();
    bus.enable_i = 1'b0;
    bus.cr_clk_div_i = 16'd868;
    bus.cr_ds_i = 1'b1;
    bus.cr_p_i = 2'd2;
    bus.cr_s_i = 1'b1;
    #12;
    check("reset", RST);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      bus.push_i = tbl[i].push;
      bus.push_data_i = tbl[i].data;
      bus.flush_i = tbl[i].flush;
      bus.enable_i = tbl[i].en;
      bus.done_i = tbl[i].done;
      bus.cr_clk_div_i = tbl[i].div;
      step();
      sh = (tbl[i].odiv != 16'h0) ? SH : 4'h0;
      check($sformatf("vec%0d", i),
        pk(tbl[i].tx, tbl[i].busy, tbl[i].dr, tbl[i].lvl,
           tbl[i].emp, tbl[i].full, tbl[i].ovf,
           tbl[i].odiv, sh));
    end

    // Launch spacing: done + 2 cycles, in push order.
    idle_in();
    do_reset();
    bus.enable_i = 1'b1;
    bus.cr_clk_div_i = 16'd868;
    bus.push_i = 1'b1;
    bus.push_data_i = 8'h11;
    step();
    bus.push_data_i = 8'h22;
    step();
    check("sp_first", pk(1,1,8'h11,1,0,0,0,868,SH));
    bus.push_data_i = 8'h33;
    step();
    bus.push_i = 1'b0;
    for (k = 0; k < 2; k++) begin
      repeat (38) step();
      bus.done_i = 1'b1;
      step();
      bus.done_i = 1'b0;
      check($sformatf("sp_done%0d", k),
        pk(0,0,seq[k],3'(2-k),0,0,0,868,SH));
      step();
      check($sformatf("sp_launch%0d", k),
        pk(1,1,seq[k+1],3'(1-k),1'(k),0,0,868,SH));
    end

    // Async reset in WAIT; no launch afterwards.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", RST);
    #2;
    rst_n = 1'b1;
    k = 0;
    repeat (6) begin
      step();
      if (bus.transmit_o) k++;
    end
    n_run++;
    if (k != 0) begin
      n_fail++;
      $display("FAIL post_rst_tx: got %0d pulses expected 0", k);
    end

    // Flush with a full FIFO while a frame is in flight.
    do_reset();
    bus.push_i = 1'b1;
    bus.push_data_i = 8'h01;
    step();
    bus.push_i = 1'b0;
    step();
    step();
    for (int b = 2; b < 6; b++) begin
      bus.push_i = 1'b1;
      bus.push_data_i = 8'(b);
      step();
    end
    check("fl_full", pk(0,1,8'h01,4,0,1,0,868,SH));
    bus.push_data_i = 8'h06;
    bus.flush_i = 1'b1;
    step();
    idle_in();
    check("fl_flush", pk(0,1,8'h01,0,1,0,0,868,SH));
    step();
    check("fl_ovf", pk(0,1,8'h01,0,1,0,0,868,SH));
    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0;
    check("fl_done", pk(0,0,8'h01,0,1,0,0,868,SH));
    k = 0;
    repeat (5) begin
      step();
      if (bus.transmit_o) k++;
    end
    n_run++;
    if (k != 0) begin
      n_fail++;
      $display("FAIL fl_no_launch: got %0d pulses expected 0", k);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_scheduler.md
Name: tx_scheduler

Overview:
- Sequences the UART transmit frontend from the register side.
- Buffers bytes written by the Wishbone slave in a small FIFO and issues one transmit pulse per byte.
- Waits for frame completion before launching the next byte.
- Shadows the frame configuration (clock divider, data size, parity, stop bits) at each frame launch, so CR writes never corrupt an in-flight frame.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- push_i  in  1  write strobe from the register file, one byte per cycle
- push_data_i  in  8  byte to enqueue
- flush_i  in  1  discard all queued bytes
- enable_i  in  1  transmitter enable; low = no new launches
- cr_clk_div_i  in  16  live CR clock divider
- cr_ds_i  in  1  live CR data size (1 = 8 bits, 0 = 7 bits)
- cr_p_i  in  2  live CR parity mode
- cr_s_i  in  1  live CR stop bits (1 = two)
- done_i  in  1  frame-complete pulse from the frontend
- transmit_o  out  1  one-cycle launch pulse to the frontend
- dr_o  out  8  byte for the current frame
- clk_div_o  out  16  shadowed divider
- ds_o  out  1  shadowed data size
- p_o  out  2  shadowed parity mode
- s_o  out  1  shadowed stop-bit setting
- busy_o  out  1  frame launched and not yet done
- empty_o  out  1  FIFO empty
- full_o  out  1  FIFO full
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- overflow_o  out  1  one-cycle pulse: push dropped because FIFO full

Behaviour:
Reset (asynchronous, rst_ni low):
- FIFO pointers and level clear; state = IDLE.
- transmit_o = 0, busy_o = 0, overflow_o = 0, dr_o = 0.
- clk_div_o = 0, ds_o = 0, p_o = 0, s_o = 0.
- empty_o = 1, full_o = 0, level_o = 0.

FIFO:
- Circular buffer with log2(DEPTH)-bit read/write pointers wrapping naturally; level_o is a separate counter.
- empty_o, full_o and level_o are registered and reflect the level after the last clock edge.
- Push is accepted iff push_i & !full_o & !flush_i, evaluated against pre-pop state.
- Push while full_o: byte dropped, overflow_o = 1 next cycle. This holds even if a pop occurs the same cycle.
- Simultaneous accepted push and pop: level unchanged, both pointers advance.
- flush_i: resets pointers and level next cycle; wins over push (no overflow pulse) and over pop. The byte already in dr_o is unaffected; an in-flight frame completes.

State machine (registered outputs):
- IDLE: when enable_i & !empty_o & !flush_i, go to LAUNCH. On that edge:
  - pop FIFO head into dr_o;
  - latch cr_* into the shadow outputs;
  - set transmit_o = 1 and busy_o = 1.
- LAUNCH (exactly 1 cycle, transmit_o = 1): go to WAIT; transmit_o = 0 next cycle.
- WAIT: hold dr_o and shadows stable. When done_i = 1, go to IDLE and set busy_o = 0.
- done_i in IDLE or LAUNCH is ignored.
- enable_i deasserted in LAUNCH or WAIT does not abort the frame; it only blocks the next IDLE->LAUNCH.

Latency:
- Push into an empty FIFO at edge N (enable_i = 1): empty_o = 0 after N, transmit_o = 1 after N+1.
- done_i at edge M with FIFO non-empty: IDLE after M, transmit_o = 1 after M+1.
- Minimum spacing between launches is therefore done_i + 2 cycles.

Shadows:
- Change only on the IDLE->LAUNCH edge.
- CR writes during WAIT take effect on the following frame.

Test Plan:
- Reset, enable_i = 1, push 0xA5 -> transmit_o high exactly one cycle, 2 cycles after the push edge; dr_o = 0xA5; busy_o = 1; level_o = 0 after launch.
- Push 0x11, 0x22, 0x33; pulse done_i 40 cycles after each launch -> three launches, dr_o = 0x11, 0x22, 0x33 in order; each transmit_o rises 2 cycles after the preceding done_i.
- DEPTH = 4, enable_i = 0, push 5 bytes -> full_o = 1 after 4th, level_o = 4, overflow_o pulses once on 5th; enable_i = 1 drains exactly 4 bytes.
- cr_clk_div_i = 868 at launch, change to 434 during WAIT -> clk_div_o stays 868 until done_i; next launch shows 434.
- With FIFO full, assert push_i + flush_i together -> level_o = 0, empty_o = 1, no overflow_o; in-flight frame finishes on done_i with no further launch.
- rst_ni low during WAIT (asynchronous, mid-cycle) -> all outputs at reset values immediately; after release no transmit_o until a new push.
